// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/grant types and constants for the memory port arbiter
package mem_arb_pkg;
    typedef logic [1:0] arb_state_t;
    localparam arb_state_t ST_IDLE  = 2'd0;
    localparam arb_state_t ST_ISSUE = 2'd1;
    localparam arb_state_t ST_WAIT  = 2'd2;
    typedef enum logic {GRANT_INSTR = 1'b0, GRANT_DATA = 1'b1} grant_t;
    localparam logic [3:0] BE_ALL = 4'b1111;
    function automatic int timeout_w(input int cycles);
        return $clog2(cycles + 1);
    endfunction
endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin pick, bit 0 = instr, bit 1 = data
module rr_arbiter_2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    output logic [1:0] gnt
);
    grant_t last_grant;
    assign gnt[0] = req[0] & (~req[1] | last_grant == GRANT_DATA);
    assign gnt[1] = req[1] & (~req[0] | last_grant == GRANT_INSTR);
    always_ff @(posedge clk) begin
        if (!rst)
            last_grant <= GRANT_DATA;
        else if (upd)
            last_grant <= gnt[1] ? GRANT_DATA : GRANT_INSTR;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory backend between the fetch and load/store ports
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid_in,
    input  logic [31:0] instr_addr_in,
    output logic        instr_ready_out,
    output logic        instr_rdata_valid_out,
    output logic [31:0] instr_rdata_out,
    output logic        instr_err_out,
    input  logic        data_valid_in,
    input  logic [31:0] data_addr_in,
    input  logic [31:0] data_wdata_in,
    input  logic [3:0]  data_byte_en_in,
    input  logic        data_read_en_in,
    input  logic        data_write_en_in,
    output logic        data_ready_out,
    output logic        data_rdata_valid_out,
    output logic [31:0] data_rdata_out,
    output logic        data_err_out,
    output logic        mem_valid_out,
    output logic [31:0] mem_addr_out,
    output logic [31:0] mem_wdata_out,
    output logic [3:0]  mem_byte_en_out,
    output logic        mem_read_en_out,
    output logic        mem_write_en_out,
    input  logic        mem_ready_in,
    input  logic        mem_rdata_valid_in,
    input  logic [31:0] mem_rdata_in
);
    localparam int TIMEOUT_W = timeout_w(TIMEOUT_CYCLES);

    arb_state_t           state;
    grant_t               grant;
    logic                 instr_done, data_done;
    logic [TIMEOUT_W-1:0] cnt;
    logic [1:0]           req, gnt;
    logic                 malformed, in_wait, cpl_ok, cpl_to, cpl;

    // a port that just completed stays masked until its valid drops
    assign req       = (state == ST_IDLE) ? {data_valid_in & ~data_done, instr_valid_in & ~instr_done} : 2'b00;
    assign malformed = data_read_en_in == data_write_en_in;
    assign in_wait   = state == ST_WAIT;
    assign cpl_ok    = in_wait & mem_ready_in;
    assign cpl_to    = in_wait & ~mem_ready_in & (cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
    assign cpl       = cpl_ok | cpl_to;

    rr_arbiter_2 u_rr (
        .clk (clk),
        .rst (rst),
        .req (req),
        .upd (|req),
        .gnt (gnt)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state                 <= ST_IDLE;
            grant                 <= GRANT_DATA;
            instr_done            <= 1'b0;
            data_done             <= 1'b0;
            cnt                   <= '0;
            instr_ready_out       <= 1'b0;
            instr_rdata_valid_out <= 1'b0;
            instr_rdata_out       <= '0;
            instr_err_out         <= 1'b0;
            data_ready_out        <= 1'b0;
            data_rdata_valid_out  <= 1'b0;
            data_rdata_out        <= '0;
            data_err_out          <= 1'b0;
            mem_valid_out         <= 1'b0;
            mem_addr_out          <= '0;
            mem_wdata_out         <= '0;
            mem_byte_en_out       <= '0;
            mem_read_en_out       <= 1'b0;
            mem_write_en_out      <= 1'b0;
        end else begin
            instr_ready_out       <= 1'b0;
            instr_rdata_valid_out <= 1'b0;
            instr_err_out         <= 1'b0;
            data_ready_out        <= 1'b0;
            data_rdata_valid_out  <= 1'b0;
            data_err_out          <= 1'b0;
            instr_done <= instr_valid_in & (instr_done | (cpl & grant == GRANT_INSTR));
            data_done  <= data_valid_in & (data_done | (cpl & grant == GRANT_DATA) | (gnt[1] & malformed));
            case (state)
                ST_IDLE: begin
                    if (gnt[0]) begin
                        grant            <= GRANT_INSTR;
                        mem_valid_out    <= 1'b1;
                        mem_addr_out     <= instr_addr_in;
                        mem_wdata_out    <= '0;
                        mem_byte_en_out  <= BE_ALL;
                        mem_read_en_out  <= 1'b1;
                        mem_write_en_out <= 1'b0;
                        state            <= ST_ISSUE;
                    end else if (gnt[1] & ~malformed) begin
                        grant            <= GRANT_DATA;
                        mem_valid_out    <= 1'b1;
                        mem_addr_out     <= data_addr_in;
                        mem_wdata_out    <= data_wdata_in;
                        mem_byte_en_out  <= data_byte_en_in;
                        mem_read_en_out  <= data_read_en_in;
                        mem_write_en_out <= data_write_en_in;
                        state            <= ST_ISSUE;
                    end else if (gnt[1]) begin
                        data_ready_out <= 1'b1;
                        data_err_out   <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    cnt   <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cpl) begin
                        mem_valid_out <= 1'b0;
                        state         <= ST_IDLE;
                        if (grant == GRANT_INSTR) begin
                            instr_ready_out       <= 1'b1;
                            instr_err_out         <= cpl_to;
                            instr_rdata_valid_out <= cpl_ok & mem_rdata_valid_in;
                            if (cpl_ok)
                                instr_rdata_out <= mem_rdata_in;
                        end else begin
                            data_ready_out       <= 1'b1;
                            data_err_out         <= cpl_to;
                            data_rdata_valid_out <= cpl_ok & mem_read_en_out & mem_rdata_valid_in;
                            if (cpl_ok & mem_read_en_out)
                                data_rdata_out <= mem_rdata_in;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
